regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of writeback requesters (0 scalar ALU, 1 vector ALU, 2 load unit).
REQ-002 SHALL have port clk  input  1: single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  N_REQ: per-requester write request valid.
REQ-005 SHALL have port req_ready  output  N_REQ: per-requester request accepted this cycle when valid.
REQ-006 SHALL have port req_addr  input  N_REQ x 4: destination register index.
REQ-007 SHALL have port req_vec  input  N_REQ: 1 = vector write, 0 = scalar write.
REQ-008 SHALL have port req_cmd  input  N_REQ x 3: command code forwarded to the register file.
REQ-009 SHALL have port req_wd  input  N_REQ x 16 x 32: write data; lane 15 carries the scalar value.
REQ-010 SHALL have port rf_hold  input  1: 1 = no grant issued this cycle.
REQ-011 SHALL have ports we3 (1), ra3 (4), wd3 (16x32), selec_v_s_w (1) and cmd (3), all outputs: registered register-file write port.
REQ-012 SHALL have port err_r15  output  1: one-cycle pulse on a dropped illegal scalar write to index 15.
REQ-013 SHALL have port perf_stall  output  N_REQ x 16: per-requester stall counters.

Function
REQ-014 SHALL hold one skid entry per requester (valid, addr, vec, cmd, data).
- req_ready[i] = ~buf_v[i] | grant[i].
- No combinational path from req_valid to req_ready.
REQ-015 SHALL load buf[i] on an edge where req_valid[i] & req_ready[i]; a simultaneous grant and load SHALL leave buf_v[i]=1 holding the new request.
REQ-016 SHALL grant at most one valid buffer per cycle, round-robin.
- Search starts at rr_ptr.
- After a grant to k, rr_ptr = (k+1) mod N_REQ.
- With no grant, rr_ptr is unchanged.
REQ-017 SHALL issue no grant while rf_hold=1; buffers and rr_ptr SHALL then hold.
REQ-018 SHALL register the granted entry into the output stage on the grant edge.
- Outputs: we3=1, ra3=addr, wd3=data, selec_v_s_w=vec, cmd=cmd.
- we3=1 lasts exactly one cycle per grant.
- Latency: a request accepted at edge N appears on we3 after edge N+1 at the earliest.
REQ-019 SHALL, when no write is issued, drive we3=0 and hold ra3, wd3, selec_v_s_w and cmd at their last values.
REQ-020 SHALL classify a granted entry as an illegal scalar write when addr==15 and (vec==0 or cmd==3'b101).
- The entry is consumed; we3 stays 0.
- err_r15 pulses for one cycle, aligned with where we3 would have asserted.
REQ-021 SHALL sustain one write per cycle aggregate when at least two buffers stay full, and one write per cycle from a single requester that keeps req_valid high.
REQ-022 SHALL NOT reorder requests from the same requester.

Reset
REQ-023 SHALL, on an edge with rst=1, clear all of the following regardless of in-flight requests:
- buf_v to 0
- rr_ptr to 0
- we3, ra3, wd3, selec_v_s_w and cmd to 0
- err_r15 to 0
- perf_stall to 0
REQ-024 SHALL drive req_ready to all-ones during the first cycle after reset deasserts; requests presented while rst=1 SHALL be discarded.

Configuration
REQ-025 SHALL compile perf_stall counting only when macro REGFILE_WB_ARB_PERF_EN is defined.
- Defined: counter i increments, saturating at 16'hFFFF, every cycle buf_v[i]=1 and grant[i]=0, including rf_hold cycles.
- Undefined: perf_stall is tied to 0, and no counter registers exist.

Verification
REQ-026 SHALL cover: one request on port 1 (addr 3, vec 1, cmd 000, lanes = lane index) at edge 0 -> we3=1 after edge 1 only, with ra3=3, selec_v_s_w=1, wd3 lane k = k.
REQ-027 SHALL cover: all three requesters hold valid continuously from reset -> grant order 0,1,2,0,1,2 with we3 high every cycle from the second cycle on.
REQ-028 SHALL cover: scalar write addr 15 (vec 0), then vector write addr 15 with cmd 101 -> we3 stays 0, err_r15 pulses twice, and both requests are consumed.
REQ-029 SHALL cover: rf_hold=1 for 4 cycles with buffers 0 and 2 full -> no we3; then with PERF_EN, perf_stall[0]=perf_stall[2]=4 and 5 after one further ungranted cycle.
REQ-030 SHALL cover: rst asserted one cycle while buffers 0 and 1 are full -> no write ever issued for either, rr_ptr=0, and next grant goes to the first valid index from 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter with one skid entry per requester.
// Optional stall counters are built only when REGFILE_WB_ARB_PERF_EN is defined.
module regfile_wb_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][3:0]        req_addr,
    input  logic [N_REQ-1:0]             req_vec,
    input  logic [N_REQ-1:0][2:0]        req_cmd,
    input  logic [N_REQ-1:0][15:0][31:0] req_wd,
    input  logic                         rf_hold,
    output logic                         we3,
    output logic [3:0]                   ra3,
    output logic [15:0][31:0]            wd3,
    output logic                         selec_v_s_w,
    output logic [2:0]                   cmd,
    output logic                         err_r15,
    output logic [N_REQ-1:0][15:0]       perf_stall
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    logic [N_REQ-1:0]             buf_v;
    logic [N_REQ-1:0][3:0]        buf_addr;
    logic [N_REQ-1:0]             buf_vec;
    logic [N_REQ-1:0][2:0]        buf_cmd;
    logic [N_REQ-1:0][15:0][31:0] buf_data;
    logic [PW-1:0]                rr_ptr;
    logic [PW-1:0]                gidx;
    logic [PW:0]                  sum;
    logic                         any_g;
    logic                         g_ill;
    logic [N_REQ-1:0]             grant;

    // Scan downward so the candidate closest to rr_ptr is the last one kept.
    always_comb begin
        gidx = '0;
        any_g = 1'b0;
        sum = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            sum = {1'b0, rr_ptr} + (PW + 1)'(j);
            sum = sum >= (PW + 1)'(N_REQ) ? sum - (PW + 1)'(N_REQ) : sum;
            if (buf_v[sum[PW-1:0]] && !rf_hold) begin
                gidx = sum[PW-1:0];
                any_g = 1'b1;
            end
        end
        grant = any_g ? N_REQ'(1) << gidx : '0;
    end

    assign req_ready = ~buf_v | grant;
    assign g_ill = buf_addr[gidx] == 4'hF && (!buf_vec[gidx] || buf_cmd[gidx] == 3'b101);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v <= '0;
            rr_ptr <= '0;
            we3 <= 1'b0;
            ra3 <= '0;
            wd3 <= '0;
            selec_v_s_w <= 1'b0;
            cmd <= '0;
            err_r15 <= 1'b0;
        end else begin
            we3 <= any_g & ~g_ill;
            err_r15 <= any_g & g_ill;
            if (any_g)
                rr_ptr <= gidx == PW'(N_REQ - 1) ? '0 : gidx + 1'b1;
            if (any_g && !g_ill) begin
                ra3 <= buf_addr[gidx];
                wd3 <= buf_data[gidx];
                selec_v_s_w <= buf_vec[gidx];
                cmd <= buf_cmd[gidx];
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    buf_v[i] <= 1'b1;
                    buf_addr[i] <= req_addr[i];
                    buf_vec[i] <= req_vec[i];
                    buf_cmd[i] <= req_cmd[i];
                    buf_data[i] <= req_wd[i];
                end else if (grant[i]) begin
                    buf_v[i] <= 1'b0;
                end
            end
        end
    end

`ifdef REGFILE_WB_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_stall <= '0;
        else
            for (int i = 0; i < N_REQ; i++)
                if (buf_v[i] && !grant[i] && perf_stall[i] != 16'hFFFF)
                    perf_stall[i] <= perf_stall[i] + 16'd1;
    end
`else
    assign perf_stall = '0;
`endif
endmodule
